modinv_3259: RTL and testbench

Sequential modular inverter over GF(3259): accepts a 12-bit operand and returns a^(q-2) mod 3259, which is a^-1 for every nonzero a (Fermat, q prime). It is the inverse-direction companion to the combinational mod-3259 Barrett reducer. It sits in the same arithmetic datapath and feeds normalisation and division steps with canonical residues in [0, 3258]. The block is a square-and-multiply FSM with valid/ready handshakes on both sides and constant, operand-independent latency.

---
 rtl/modinv_3259.sv | 143 ++++++++++++++
 tb/tb_modinv_3259.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_3259.sv
// GF(3259) inverter: a^(Q-2) mod Q by left-to-right square-and-multiply.
// Fixed 19-cycle latency, valid/ready on both sides.
module modinv_3259 #(
  parameter int Q     = 3259,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout_r,
  output logic             zero_err
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 1;
  localparam int RW = WIDTH + 2;
  localparam int IW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] QW  = WIDTH'(Q);
  localparam logic [WIDTH-1:0] EXP = WIDTH'(Q - 2);
  localparam logic [PW-1:0]    QP  = PW'(Q);
  localparam logic [RW-1:0]    QR  = RW'(Q);
  localparam logic [IW-1:0]    TOP = IW'(WIDTH - 1);
  localparam logic [PW+MW-1:0] MU  =
    (PW+MW)'((longint'(1) << PW) / longint'(Q));

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;

  logic             accept;
  logic             step;
  logic             dec;
  logic             last;

  logic [WIDTH-1:0] a_red;
  logic [WIDTH-1:0] mul_b;
  logic [PW-1:0]    prod;
  logic [PW+MW-1:0] pm;
  logic [MW-1:0]    t;
  logic [PW-1:0]    tq;
  logic [RW-1:0]    r0;
  logic [RW-1:0]    r1;
  logic [RW-1:0]    r2;
  logic [WIDTH-1:0] red;

  // 4095 < 2Q, so one subtract canonicalises the operand
  assign a_red = (din_a >= QW) ? din_a - QW : din_a;

  assign mul_b = (state == MUL) ? a_reg : acc;
  assign prod  = PW'(acc) * PW'(mul_b);

  // Barrett: quotient estimate is short by at most 2, remainder < 3Q
  assign pm  = (PW+MW)'(prod) * MU;
  assign t   = MW'(pm >> PW);
  assign tq  = PW'(t) * QP;
  assign r0  = RW'(prod - tq);
  assign r1  = (r0 >= QR) ? r0 - QR : r0;
  assign r2  = (r1 >= QR) ? r1 - QR : r1;
  assign red = WIDTH'(r2);

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    dec       = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = SQR;
        end
      end
      SQR: begin
        step = 1'b1;
        if (EXP[idx]) begin
          state_n = MUL;
        end else if (idx == '0) begin
          last    = 1'b1;
          state_n = DONE;
        end else begin
          dec = 1'b1;
        end
      end
      MUL: begin
        step = 1'b1;
        if (idx == '0) begin
          last    = 1'b1;
          state_n = DONE;
        end else begin
          dec     = 1'b1;
          state_n = SQR;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      acc      <= WIDTH'(1);
      idx      <= TOP;
      dout_r   <= '0;
      zero_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_reg    <= a_red;
        acc      <= WIDTH'(1);
        idx      <= TOP;
        zero_err <= (a_red == '0);
      end else if (step) begin
        acc <= red;
        if (dec) idx <= idx - IW'(1);
        if (last) dout_r <= red;
      end
    end
  end

endmodule

// File: tb/tb_modinv_3259.sv
// Scoreboard bench for modinv_3259: directed, backpressure,
// mid-op reset, full nonzero sweep and random operands.
module tb_modinv_3259;

  localparam int Q   = 3259;
  localparam int LAT = 19;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] din_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dout_r;
  logic        zero_err;

  typedef struct {
    logic [11:0] a;
    logic [11:0] r;
    logic        z;
    int          t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   bp_req = 0;

  modinv_3259 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Extended Euclid; 0 for operands congruent to 0
  function automatic int inv_ref(input int a);
    int r, t, nt, rr, nr, qq, tmp;
    r = a % Q;
    if (r == 0) return 0;
    t = 0; nt = 1; rr = Q; nr = r;
    while (nr != 0) begin
      qq = rr / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = rr - qq * nr; rr = nr; nr = tmp;
    end
    if (t < 0) t += Q;
    return t;
  endfunction

  task automatic issue(input int a, input int r, input bit z);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    din_a = 12'(a);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++; errors++;
      $display("FAIL accept_timeout a=%0d", a);
      return;
    end
    e.a = 12'(a); e.r = 12'(r); e.z = z; e.t = cyc;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic issue_ref(input int a);
    issue(a, inv_ref(a), (a % Q) == 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
    end
  endtask

  task automatic check_reset(input string nm);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        dout_r !== 12'd0 || zero_err !== 1'b0) begin
      errors++;
      $display("FAIL %s got rdy=%b vld=%b r=%0d z=%b want 1 0 0 0",
               nm, in_ready, out_valid, dout_r, zero_err);
    end
  endtask

  // Monitor: pops on each new result, checks value, latency, hold
  initial begin : monitor
    bit          holding;
    int          hold_n;
    int          lat;
    logic [11:0] hold_d;
    logic        hold_z;
    exp_t        e;
    holding = 1'b0;
    hold_n = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
        out_ready = 1'b1;
      end else if (out_valid && !holding) begin
        holding = 1'b1;
        hold_n = 0;
        hold_d = dout_r;
        hold_z = zero_err;
        if (q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_out got r=%0d want none", dout_r);
        end else begin
          e = q.pop_front();
          vectors++;
          if (dout_r !== e.r || zero_err !== e.z) begin
            errors++;
            $display("FAIL result a=%0d got r=%0d z=%b want r=%0d z=%b",
                     e.a, dout_r, zero_err, e.r, e.z);
          end
          lat = cyc - e.t - 1;
          vectors++;
          if (lat != LAT) begin
            errors++;
            $display("FAIL latency a=%0d got %0d want %0d", e.a, lat, LAT);
          end
          if (!e.z) begin
            vectors++;
            if (((int'(e.a) % Q) * int'(dout_r)) % Q != 1) begin
              errors++;
              $display("FAIL inverse a=%0d got r=%0d want a*r=1", e.a, dout_r);
            end
          end
        end
        out_ready = (bp_req == 0);
      end else if (out_valid) begin
        hold_n++;
        vectors++;
        if (dout_r !== hold_d || zero_err !== hold_z || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold got r=%0d z=%b rdy=%b want r=%0d z=%b rdy=0",
                   dout_r, zero_err, in_ready, hold_d, hold_z);
        end
        out_ready = (hold_n >= bp_req);
      end else if (holding) begin
        holding = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL release_ready got %b want 1", in_ready);
        end
      end
    end
  end

  initial begin : stim
    int dir_a[7];
    int dir_r[7];
    bit dir_z[7];
    int n;
    bit bad;
    dir_a = '{2, 3, 1, 3258, 3261, 0, 3259};
    dir_r = '{1630, 2173, 1, 3258, 1630, 0, 0};
    dir_z = '{0, 0, 0, 0, 0, 1, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    din_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) issue(dir_a[i], dir_r[i], dir_z[i]);
    drain();

    bp_req = 5;
    issue(2, 1630, 1'b0);
    drain();
    bp_req = 0;

    @(negedge clk);
    din_a = 12'd2;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_op_reset");
    rst = 1'b0;
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL discarded_result got out_valid=1 want 0");
    end

    issue(3, 2173, 1'b0);
    drain();

    for (int a = 1; a < Q; a++) issue_ref(a);
    drain();

    for (int k = 0; k < 100; k++) issue_ref(int'($urandom_range(0, 4095)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
